// File: rtl/alu_mc_if.sv
// Request/result bundle for the multi-cycle ALU.
// The CPU side (master) drives the request; the ALU (slave) returns the result.
interface alu_mc_if #(
    parameter int N = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] x;
    logic [N-1:0] y;
    logic [3:0]   mode;
    logic [N-1:0] z;
    logic [N-1:0] hi;
    logic         out_valid;
    logic         busy;

    modport master (
        output in_valid, x, y, mode,
        input  in_ready, z, hi, out_valid, busy
    );

    modport slave (
        input  in_valid, x, y, mode,
        output in_ready, z, hi, out_valid, busy
    );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle ALU.
// Single-cycle ops complete at the accept edge.
// MUL uses shift-add and DIV uses restoring division. Both retire one bit per
// clock and write z and hi together after N iterations.
module alu_mc #(
    parameter int N = 32
) (
    input  logic      clk,
    input  logic      rst,
    alu_mc_if.slave   bus
);
    localparam int SW = $clog2(N);
    localparam int CW = $clog2(N) + 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(N);
    localparam logic [CW-1:0] CNT_LAST = CW'(1);

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_MUL  = 4'h3;
    localparam logic [3:0] OP_DIV  = 4'h4;
    localparam logic [3:0] OP_AND  = 4'h5;
    localparam logic [3:0] OP_OR   = 4'h6;
    localparam logic [3:0] OP_XOR  = 4'h7;
    localparam logic [3:0] OP_NOR  = 4'h8;
    localparam logic [3:0] OP_SLL  = 4'h9;
    localparam logic [3:0] OP_SRL  = 4'hA;
    localparam logic [3:0] OP_SLT  = 4'hB;
    localparam logic [3:0] OP_SRA  = 4'hC;
    localparam logic [3:0] OP_MFHI = 4'hD;
    localparam logic [3:0] OP_EQ   = 4'hE;
    localparam logic [3:0] OP_NEQ  = 4'hF;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [N-1:0]   z_reg, z_next;
    logic [N-1:0]   hi_reg, hi_next;
    logic           out_valid_reg, out_valid_next;
    logic [CW-1:0]  cnt_reg, cnt_next;

    // Multiplier state.
    // Full-width product accumulator, left-shifting multiplicand, and
    // right-shifting multiplier.
    logic [2*N-1:0] prod_reg, prod_next;
    logic [2*N-1:0] mcand_reg, mcand_next;
    logic [N-1:0]   mplier_reg, mplier_next;

    // Divider state.
    // quot_reg starts as the dividend. Each cycle its top bit moves into the
    // remainder and the new quotient bit enters at the bottom.
    logic [N-1:0]   rem_reg, rem_next;
    logic [N-1:0]   quot_reg, quot_next;
    logic [N-1:0]   divisor_reg, divisor_next;

    // Per-iteration datapath values.
    logic [2*N-1:0] mul_acc;
    logic [N:0]     div_trial;
    logic           div_ge;
    logic [N-1:0]   div_rem;
    logic [N-1:0]   div_quot;

    // Single-cycle result path.
    logic [SW-1:0]  sh_amt;
    logic [N-1:0]   and_v, or_v, xor_v, nor_v;
    logic [N-1:0]   alu_result;
    logic           is_last;

    assign sh_amt  = bus.y[SW-1:0];
    assign is_last = (cnt_reg == CNT_LAST);

    // Bitwise logic unit, one slice per bit.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_logic
            assign and_v[gi] = bus.x[gi] & bus.y[gi];
            assign or_v[gi]  = bus.x[gi] | bus.y[gi];
            assign xor_v[gi] = bus.x[gi] ^ bus.y[gi];
            assign nor_v[gi] = ~(bus.x[gi] | bus.y[gi]);
        end
    endgenerate

    // One shift-add step: add the shifted multiplicand when the multiplier LSB is set.
    assign mul_acc = mplier_reg[0] ? (prod_reg + mcand_reg) : prod_reg;

    // One restoring-division step.
    // With a zero divisor the compare always succeeds, which gives an all-ones
    // quotient and leaves the dividend in the remainder.
    assign div_trial = {rem_reg, quot_reg[N-1]};
    assign div_ge    = (div_trial >= {1'b0, divisor_reg});
    assign div_rem   = div_ge ? (div_trial[N-1:0] - divisor_reg) : div_trial[N-1:0];
    assign div_quot  = {quot_reg[N-2:0], div_ge};

    // Combinational result for every single-cycle opcode.
    always_comb begin
        alu_result = '0;
        case (bus.mode)
            OP_NOP:  alu_result = '0;
            OP_ADD:  alu_result = bus.x + bus.y;
            OP_SUB:  alu_result = bus.x - bus.y;
            OP_AND:  alu_result = and_v;
            OP_OR:   alu_result = or_v;
            OP_XOR:  alu_result = xor_v;
            OP_NOR:  alu_result = nor_v;
            OP_SLL:  alu_result = bus.x << sh_amt;
            OP_SRL:  alu_result = bus.x >> sh_amt;
            OP_SLT:  alu_result = {{(N-1){1'b0}}, (bus.x < bus.y)};
            OP_SRA:  alu_result = $unsigned($signed(bus.x) >>> sh_amt);
            OP_MFHI: alu_result = hi_reg;
            OP_EQ:   alu_result = {{(N-1){1'b0}}, (bus.x == bus.y)};
            OP_NEQ:  alu_result = {{(N-1){1'b0}}, (bus.x != bus.y)};
            default: alu_result = '0;
        endcase
    end

    // Next-state logic and datapath updates for the IDLE/MUL/DIV controller.
    always_comb begin
        state_next     = state_reg;
        z_next         = z_reg;
        hi_next        = hi_reg;
        out_valid_next = 1'b0;
        cnt_next       = cnt_reg;
        prod_next      = prod_reg;
        mcand_next     = mcand_reg;
        mplier_next    = mplier_reg;
        rem_next       = rem_reg;
        quot_next      = quot_reg;
        divisor_next   = divisor_reg;

        case (state_reg)
            S_IDLE: begin
                if (bus.in_valid) begin
                    if (bus.mode == OP_MUL) begin
                        prod_next   = '0;
                        mcand_next  = {{N{1'b0}}, bus.x};
                        mplier_next = bus.y;
                        cnt_next    = CNT_INIT;
                        state_next  = S_MUL;
                    end else if (bus.mode == OP_DIV) begin
                        rem_next     = '0;
                        quot_next    = bus.x;
                        divisor_next = bus.y;
                        cnt_next     = CNT_INIT;
                        state_next   = S_DIV;
                    end else begin
                        z_next         = alu_result;
                        out_valid_next = 1'b1;
                    end
                end
            end

            S_MUL: begin
                prod_next   = mul_acc;
                mcand_next  = mcand_reg << 1;
                mplier_next = mplier_reg >> 1;
                cnt_next    = cnt_reg - CNT_LAST;
                if (is_last) begin
                    z_next         = mul_acc[N-1:0];
                    hi_next        = mul_acc[2*N-1:N];
                    out_valid_next = 1'b1;
                    state_next     = S_IDLE;
                end
            end

            S_DIV: begin
                rem_next  = div_rem;
                quot_next = div_quot;
                cnt_next  = cnt_reg - CNT_LAST;
                if (is_last) begin
                    z_next         = div_quot;
                    hi_next        = div_rem;
                    out_valid_next = 1'b1;
                    state_next     = S_IDLE;
                end
            end

            default: state_next = S_IDLE;
        endcase
    end

    // State and datapath registers. Reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            z_reg         <= '0;
            hi_reg        <= '0;
            out_valid_reg <= 1'b0;
            cnt_reg       <= '0;
            prod_reg      <= '0;
            mcand_reg     <= '0;
            mplier_reg    <= '0;
            rem_reg       <= '0;
            quot_reg      <= '0;
            divisor_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            z_reg         <= z_next;
            hi_reg        <= hi_next;
            out_valid_reg <= out_valid_next;
            cnt_reg       <= cnt_next;
            prod_reg      <= prod_next;
            mcand_reg     <= mcand_next;
            mplier_reg    <= mplier_next;
            rem_reg       <= rem_next;
            quot_reg      <= quot_next;
            divisor_reg   <= divisor_next;
        end
    end

    assign bus.z         = z_reg;
    assign bus.hi        = hi_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.in_ready  = (state_reg == S_IDLE);
    assign bus.busy      = (state_reg != S_IDLE);

endmodule
